// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: RAM handshake state, arbiter FSM state, grant owner.
package mem_request_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, DACC, IACC, DHIT, IHIT} arb_state_t;
  typedef enum logic {INSTR, DATA} grant_t;

  function automatic logic misaligned(word_t a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/mem_request_arbiter_if.sv
// Datapath request/hit signals plus the single cpu_ram_if style RAM port.
interface mem_request_arbiter_if;
  import mem_request_arbiter_pkg::*;

  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      ihit, dhit, memerr;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, memerr, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, memerr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_request_arbiter_access_timer.sv
// Saturating cycle counter bounding how long one RAM access may stay outstanding.
module mem_request_arbiter_access_timer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_request_arbiter.sv
// Serialises fetch and data requests onto one RAM port, alternating grants under contention,
// and returns single-cycle ihit/dhit pulses with load data.
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic CLK,
  input logic nRST,
  mem_request_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  word_t      addr_q, addr_d, store_q, store_d;
  word_t      iload_q, iload_d, dload_q, dload_d;
  logic       wr_q, wr_d, memerr_q, memerr_d;
  logic       tmr_clr, tmr_en, tmr_expired;
  logic       d_req, i_req, d_pick;

  mem_request_arbiter_access_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(CLK), .rst_n(nRST), .clr(tmr_clr), .en(tmr_en), .expired(tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wr_d         = wr_q;
    iload_d      = iload_q;
    dload_d      = dload_q;
    memerr_d     = memerr_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    d_req        = bus.dREN | bus.dWEN;
    i_req        = bus.iREN;
    d_pick       = d_req && (!i_req || last_grant_q == INSTR);
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (d_pick) begin
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wr_d    = bus.dWEN;
          // Misaligned requests still get a hit so the datapath cannot stall forever.
          if (misaligned(bus.daddr)) begin
            memerr_d     = 1'b1;
            if (!bus.dWEN) dload_d = '0;
            last_grant_d = DATA;
            state_d      = DHIT;
          end else state_d = DACC;
        end else if (i_req) begin
          addr_d = bus.iaddr;
          wr_d   = 1'b0;
          if (misaligned(bus.iaddr)) begin
            memerr_d     = 1'b1;
            iload_d      = '0;
            last_grant_d = INSTR;
            state_d      = IHIT;
          end else state_d = IACC;
        end
      end
      DACC: begin
        tmr_en = 1'b1;
        if (!d_req) state_d = IDLE;
        else if (bus.ramstate == ACCESS) begin
          if (!wr_q) dload_d = bus.ramload;
          last_grant_d = DATA;
          state_d      = DHIT;
        end else if (bus.ramstate == ERROR || tmr_expired) begin
          memerr_d     = 1'b1;
          if (!wr_q) dload_d = '0;
          last_grant_d = DATA;
          state_d      = DHIT;
        end
      end
      IACC: begin
        tmr_en = 1'b1;
        if (!i_req) state_d = IDLE;
        else if (bus.ramstate == ACCESS) begin
          iload_d      = bus.ramload;
          last_grant_d = INSTR;
          state_d      = IHIT;
        end else if (bus.ramstate == ERROR || tmr_expired) begin
          memerr_d     = 1'b1;
          iload_d      = '0;
          last_grant_d = INSTR;
          state_d      = IHIT;
        end
      end
      DHIT, IHIT: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
      addr_q       <= '0;
      store_q      <= '0;
      wr_q         <= 1'b0;
      iload_q      <= '0;
      dload_q      <= '0;
      memerr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wr_q         <= wr_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
      memerr_q     <= memerr_d;
    end
  end

  assign bus.ramREN   = (state_q == IACC) || (state_q == DACC && !wr_q);
  assign bus.ramWEN   = (state_q == DACC) && wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = (state_q == IHIT);
  assign bus.dhit     = (state_q == DHIT);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.memerr   = memerr_q;
endmodule
